// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit (master) and the RV64I datapath (slave).
// The master receives IR fields and ALU flags and drives every enable, select and the debug state code.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       lt;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       ab_load;
    logic       aluout_load;
    logic       mdr_load;
    logic       reg_write;
    logic       dmem_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       halted;
    logic [4:0] state;

    modport master (
        input  opcode, funct3, funct7, zero, lt,
        output pc_write, pc_src, ir_write, ab_load, aluout_load, mdr_load,
               reg_write, dmem_write, wb_sel, alu_src_a, alu_src_b, alu_op,
               halted, state
    );

    modport slave (
        output opcode, funct3, funct7, zero, lt,
        input  pc_write, pc_src, ir_write, ab_load, aluout_load, mdr_load,
               reg_write, dmem_write, wb_sel, alu_src_a, alu_src_b, alu_op,
               halted, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-style multicycle control FSM for the RV64I datapath (fetch / decode / execute sequencing).
// Outputs decode combinationally from the state register, IR fields and, in BRANCH only, the ALU flags.
module multicycle_control_unit (
    input  logic clk,
    input  logic reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_R_EXEC     = 5'd4,
        S_I_EXEC     = 5'd5,
        S_ALU_WB     = 5'd6,
        S_MEM_ADDR   = 5'd7,
        S_LOAD_REQ   = 5'd8,
        S_LOAD_WAIT  = 5'd9,
        S_LOAD_WB    = 5'd10,
        S_STORE      = 5'd11,
        S_BRANCH     = 5'd12,
        S_JAL        = 5'd13,
        S_JALR       = 5'd14,
        S_LUI        = 5'd15,
        S_HALT       = 5'd16
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    state_t cur, nxt;
    logic   taken;

    always_ff @(posedge clk) begin
        if (reset) cur <= S_RESET;
        else       cur <= nxt;
    end

    always_comb begin
        nxt             = cur;
        taken           = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'd0;
        bus.ir_write    = 1'b0;
        bus.ab_load     = 1'b0;
        bus.aluout_load = 1'b0;
        bus.mdr_load    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.dmem_write  = 1'b0;
        bus.wb_sel      = 2'd0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'd0;
        bus.alu_op      = OP_ADD;
        bus.halted      = 1'b0;
        case (cur)
            S_RESET:      nxt = S_FETCH;
            S_FETCH:      nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                bus.ir_write = 1'b1;
                nxt          = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively computes PC+imm into ALUOut for branches and JAL.
                bus.ab_load     = 1'b1;
                bus.aluout_load = 1'b1;
                bus.alu_src_b   = 2'd2;
                case (bus.opcode)
                    7'b0110011:             nxt = S_R_EXEC;
                    7'b0010011:             nxt = S_I_EXEC;
                    7'b0000011, 7'b0100011: nxt = S_MEM_ADDR;
                    7'b1100011:             nxt = S_BRANCH;
                    7'b1101111:             nxt = S_JAL;
                    7'b1100111:             nxt = S_JALR;
                    7'b0110111:             nxt = S_LUI;
                    default:                nxt = S_HALT;
                endcase
            end
            S_R_EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.aluout_load = 1'b1;
                nxt             = S_ALU_WB;
                case ({bus.funct7, bus.funct3})
                    10'b0000000_000: bus.alu_op = OP_ADD;
                    10'b0100000_000: bus.alu_op = OP_SUB;
                    10'b0000000_111: bus.alu_op = OP_AND;
                    10'b0000000_100: bus.alu_op = OP_XOR;
                    10'b0000000_010: bus.alu_op = OP_SLT;
                    default:         nxt        = S_HALT;
                endcase
            end
            S_I_EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.aluout_load = 1'b1;
                nxt             = S_ALU_WB;
                case (bus.funct3)
                    3'b000:  bus.alu_op = OP_ADD;
                    3'b010:  bus.alu_op = OP_SLT;
                    default: nxt        = S_HALT;
                endcase
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
                nxt           = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.aluout_load = 1'b1;
                if (bus.funct3 != 3'b010 && bus.funct3 != 3'b011) nxt = S_HALT;
                else if (bus.opcode == 7'b0000011)                nxt = S_LOAD_REQ;
                else                                              nxt = S_STORE;
            end
            S_LOAD_REQ:  nxt = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                bus.mdr_load = 1'b1;
                nxt          = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = 2'd1;
                bus.pc_write  = 1'b1;
                nxt           = S_FETCH;
            end
            S_STORE: begin
                bus.dmem_write = 1'b1;
                bus.pc_write   = 1'b1;
                nxt            = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = OP_SUB;
                bus.pc_write  = 1'b1;
                nxt           = S_FETCH;
                case (bus.funct3)
                    3'b000:  taken = bus.zero;
                    3'b001:  taken = !bus.zero;
                    3'b100:  taken = bus.lt;
                    3'b101:  taken = !bus.lt;
                    default: begin
                        bus.pc_write = 1'b0;
                        nxt          = S_HALT;
                    end
                endcase
                bus.pc_src = taken ? 2'd1 : 2'd0;
            end
            S_JAL: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = 2'd2;
                bus.pc_write  = 1'b1;
                bus.pc_src    = 2'd1;
                nxt           = S_FETCH;
            end
            S_JALR: begin
                // Target uses A latched in DECODE, so rd == rs1 cannot corrupt it.
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.reg_write = 1'b1;
                bus.wb_sel    = 2'd2;
                bus.pc_write  = 1'b1;
                bus.pc_src    = 2'd2;
                nxt           = S_FETCH;
            end
            S_LUI: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = 2'd3;
                bus.pc_write  = 1'b1;
                nxt           = S_FETCH;
            end
            S_HALT:  bus.halted = 1'b1;
            default: nxt = S_HALT;
        endcase
        // A reset landing mid-instruction must not commit any architectural write.
        if (reset) begin
            bus.pc_write   = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.dmem_write = 1'b0;
        end
    end

    assign bus.state = cur;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class state by state
// and compares the state code plus the full packed control vector against hand-computed constants.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packed layout: pc_write pc_src[2] ir_write ab_load aluout_load mdr_load reg_write
    //                dmem_write wb_sel[2] alu_src_a alu_src_b[2] alu_op[3] halted
    localparam logic [17:0] PCW  = 18'h20000;
    localparam logic [17:0] PCS2 = 18'h10000;
    localparam logic [17:0] PCS1 = 18'h08000;
    localparam logic [17:0] IRW  = 18'h04000;
    localparam logic [17:0] ABL  = 18'h02000;
    localparam logic [17:0] AOL  = 18'h01000;
    localparam logic [17:0] MDRL = 18'h00800;
    localparam logic [17:0] RW   = 18'h00400;
    localparam logic [17:0] DMW  = 18'h00200;
    localparam logic [17:0] WB3  = 18'h00180;
    localparam logic [17:0] WB2  = 18'h00100;
    localparam logic [17:0] WB1  = 18'h00080;
    localparam logic [17:0] SA   = 18'h00040;
    localparam logic [17:0] SB2  = 18'h00020;
    localparam logic [17:0] SUB  = 18'h00002;
    localparam logic [17:0] ANDO = 18'h00004;
    localparam logic [17:0] XORO = 18'h00006;
    localparam logic [17:0] SLT  = 18'h00008;
    localparam logic [17:0] HLT  = 18'h00001;
    localparam logic [17:0] DEC  = ABL | AOL | SB2;

    function automatic logic [17:0] ctl();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.ab_load, bus.aluout_load,
                bus.mdr_load, bus.reg_write, bus.dmem_write, bus.wb_sel, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.halted};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [4:0] st, input logic [17:0] c);
        n_checks++;
        assert (bus.state === st) else begin
            n_fails++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.state, st);
        end
        n_checks++;
        assert (ctl() === c) else begin
            n_fails++;
            $error("FAIL %s ctl: observed %05h expected %05h", tag, ctl(), c);
        end
    endtask

    task automatic set_ir(input logic [31:0] ir);
        bus.opcode = ir[6:0];
        bus.funct3 = ir[14:12];
        bus.funct7 = ir[31:25];
    endtask

    // Checks FETCH, FETCH_WAIT, DECODE and leaves the FSM in the execute state.
    task automatic front(input string tag);
        expect_st({tag, "_f"}, 5'd1, 18'h0); tick();
        expect_st({tag, "_fw"}, 5'd2, IRW); tick();
        expect_st({tag, "_dec"}, 5'd3, DEC); tick();
    endtask

    task automatic reset_to_fetch(input string tag);
        reset = 1'b1; tick();
        expect_st({tag, "_rst"}, 5'd0, 18'h0);
        reset = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b1; bus.zero = 1'b0; bus.lt = 1'b0;
        set_ir(32'h00500093);
        tick(); tick();
        expect_st("por", 5'd0, 18'h0);
        reset = 1'b0; tick();

        // addi x1,x0,5
        front("addi");
        expect_st("addi_iexec", 5'd5, AOL | SA | SB2); tick();
        expect_st("addi_wb", 5'd6, RW | PCW); tick();

        // sub, xor, and, slt (R-type)
        set_ir(32'h402081B3); front("sub");
        expect_st("sub_rexec", 5'd4, AOL | SA | SUB); tick();
        expect_st("sub_wb", 5'd6, RW | PCW); tick();
        set_ir(32'h0020C1B3); front("xor");
        expect_st("xor_rexec", 5'd4, AOL | SA | XORO); tick(); tick();
        set_ir(32'h0020F1B3); front("and");
        expect_st("and_rexec", 5'd4, AOL | SA | ANDO); tick(); tick();
        set_ir(32'h0020A1B3); front("slt");
        expect_st("slt_rexec", 5'd4, AOL | SA | SLT); tick(); tick();
        set_ir(32'h0050A093); front("slti");
        expect_st("slti_iexec", 5'd5, AOL | SA | SB2 | SLT); tick(); tick();

        // ld x1,0(x2)
        set_ir(32'h00013083); front("ld");
        expect_st("ld_addr", 5'd7, AOL | SA | SB2); tick();
        expect_st("ld_req", 5'd8, 18'h0); tick();
        expect_st("ld_wait", 5'd9, MDRL); tick();
        expect_st("ld_wb", 5'd10, RW | WB1 | PCW); tick();

        // sw then reset held 3 cycles starting in STORE
        set_ir(32'h00112023); front("sw");
        expect_st("sw_addr", 5'd7, AOL | SA | SB2); tick();
        expect_st("sw_store", 5'd11, DMW | PCW);
        reset = 1'b1; #1;
        expect_st("sw_store_rst", 5'd11, 18'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_st("sw_rst_hold", 5'd0, 18'h0);
        end
        reset = 1'b0; tick();

        // beq x0,x0,+8 taken, not taken
        set_ir(32'h00000463); front("beq_t");
        bus.zero = 1'b1; #1;
        expect_st("beq_taken", 5'd12, PCW | PCS1 | SA | SUB); tick();
        front("beq_nt");
        bus.zero = 1'b0; #1;
        expect_st("beq_not", 5'd12, PCW | SA | SUB); tick();
        set_ir(32'h00001463); front("bne");
        expect_st("bne_taken", 5'd12, PCW | PCS1 | SA | SUB); tick();
        set_ir(32'h00005463); front("bge");
        bus.lt = 1'b1; #1;
        expect_st("bge_lt", 5'd12, PCW | SA | SUB); tick();
        set_ir(32'h00004463); front("blt");
        expect_st("blt_lt", 5'd12, PCW | PCS1 | SA | SUB); tick();
        bus.lt = 1'b0;

        // jal, jalr, lui
        set_ir(32'h010000EF); front("jal");
        expect_st("jal", 5'd13, RW | WB2 | PCW | PCS1); tick();
        set_ir(32'h000080E7); front("jalr");
        expect_st("jalr", 5'd14, SA | SB2 | RW | WB2 | PCW | PCS2); tick();
        set_ir(32'h123452B7); front("lui");
        expect_st("lui", 5'd15, RW | WB3 | PCW); tick();
        expect_st("lui_next", 5'd1, 18'h0);

        // undefined branch funct3 halts without a PC write
        set_ir(32'h00002463); front("bbad");
        expect_st("bbad_branch", 5'd12, SA | SUB); tick();
        expect_st("bbad_halt", 5'd16, HLT);
        reset_to_fetch("bbad");

        // break
        set_ir(32'h00100073); front("brk");
        for (int i = 0; i < 12; i++) begin
            expect_st("brk_halt", 5'd16, HLT); tick();
        end
        reset_to_fetch("brk");

        // R-type with funct7 0000001 is unsupported
        set_ir(32'h022081B3); front("mul");
        expect_st("mul_rexec", 5'd4, AOL | SA); tick();
        for (int i = 0; i < 10; i++) begin
            expect_st("mul_halt", 5'd16, HLT); tick();
        end
        reset_to_fetch("mul");
        expect_st("recover", 5'd1, 18'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control unit for the RV64I datapath. A Moore-style FSM sequences each instruction through fetch, decode and execute states. It drives the PC, IR, A/B, ALUOut and MDR load enables, the mux selects, the ALU operation, and the register-file and data-memory write enables. Opcode, funct3 and funct7 come from the IR; `zero` and `lt` come from the ALU. The immediate extender in the datapath supplies the operand chosen by `alu_src_b`=2.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  IR[6:0].
- `funct3`  in  3  IR[14:12].
- `funct7`  in  7  IR[31:25].
- `zero`  in  1  ALU result == 0.
- `lt`  in  1  ALU signed A < B.
- `pc_write`  out  1  PC load enable.
- `pc_src`  out  2  PC input select: 0 = PC+4 (dedicated incrementer), 1 = ALUOut, 2 = live ALU result.
- `ir_write`  out  1  IR load enable.
- `ab_load`  out  1  A/B register load enable.
- `aluout_load`  out  1  ALUOut load enable.
- `mdr_load`  out  1  MDR load enable.
- `reg_write`  out  1  register-file write enable.
- `dmem_write`  out  1  data-memory write enable (address = ALUOut, data = B).
- `wb_sel`  out  2  register write-back source: 0 = ALUOut, 1 = MDR, 2 = PC+4, 3 = immediate.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B input: 0 = B, 1 = constant 4, 2 = immediate.
- `alu_op`  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SLT.
- `halted`  out  1  high while in HALT.
- `state`  out  5  current state code, for debug.

## Operation
- State codes: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, R_EXEC 4, I_EXEC 5, ALU_WB 6, MEM_ADDR 7, LOAD_REQ 8, LOAD_WAIT 9, LOAD_WB 10, STORE 11, BRANCH 12, JAL 13, JALR 14, LUI 15, HALT 16.
- Outputs not listed for a state are 0.

**Per-state outputs and transitions**
- RESET: no outputs asserted; next FETCH.
- FETCH: instruction memory is addressed by PC (registered read); next FETCH_WAIT.
- FETCH_WAIT: `ir_write`; next DECODE.
- DECODE: `ab_load`, `aluout_load`, `alu_src_a`=0, `alu_src_b`=2, ADD. This computes the branch/jump target PC+imm. Next state by opcode:
  - 0110011 → R_EXEC
  - 0010011 → I_EXEC
  - 0000011 and 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else, including 1110011 (break) → HALT
- R_EXEC: `alu_src_a`=1, `alu_src_b`=0, `aluout_load`. Decode of {funct7, funct3}:
  - {0000000, 000} → ADD
  - {0100000, 000} → SUB
  - {0000000, 111} → AND
  - {0000000, 100} → XOR
  - {0000000, 010} → SLT
  - Any other combination goes to HALT with no write. Otherwise next ALU_WB.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=2, `aluout_load`. funct3 000 → ADD, 010 → SLT, otherwise HALT. Next ALU_WB.
- ALU_WB: `reg_write`, `wb_sel`=0, `pc_write`, `pc_src`=0; next FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, ADD, `aluout_load`. funct3 must be 010 or 011, otherwise HALT. Next LOAD_REQ (opcode 0000011) or STORE.
- LOAD_REQ: data memory addressed by ALUOut; next LOAD_WAIT.
- LOAD_WAIT: `mdr_load`; next LOAD_WB.
- LOAD_WB: `reg_write`, `wb_sel`=1, `pc_write`, `pc_src`=0; next FETCH.
- STORE: `dmem_write`, `pc_write`, `pc_src`=0; next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_write`. `pc_src`=1 if taken, else 0 (Mealy on the flags). Next FETCH. Taken condition by funct3:
  - 000 (beq): `zero`
  - 001 (bne): !`zero`
  - 100 (blt): `lt`
  - 101 (bge): !`lt`
  - Other funct3 → HALT with `pc_write`=0.
- JAL: `reg_write`, `wb_sel`=2, `pc_write`, `pc_src`=1; next FETCH.
- JALR: `alu_src_a`=1, `alu_src_b`=2, ADD, `reg_write`, `wb_sel`=2, `pc_write`, `pc_src`=2; next FETCH. Because A was latched in DECODE, the case rd == rs1 is safe.
- LUI: `reg_write`, `wb_sel`=3, `pc_write`, `pc_src`=0; next FETCH.
- HALT: `halted`=1, no write enables asserted. Stays in HALT until reset.

## Timing
- On a rising edge with `reset`=1 the state becomes RESET. After reset, every output is 0 and `state`=0.
- While `reset`=1, `pc_write`, `ir_write`, `reg_write` and `dmem_write` are forced to 0 combinationally. A reset arriving mid-instruction (for example in STORE) therefore produces no write.
- The first FETCH is the cycle after the first edge with `reset`=0.
- Cycles per instruction, counted from FETCH to the cycle before the next FETCH:
  - R-type, I-type, store: 5
  - load: 7
  - branch, JAL, JALR, LUI: 4
- Outputs are functions of state, IR fields and the flags only; there is no output register stage.
- The flags are sampled only in BRANCH.

## Test plan
- Reset held 3 cycles during STORE, then released:
  - no `dmem_write` pulse while `reset` is high; `state`=0; FETCH follows one cycle later.
- IR = 0x00500093 (addi x1,x0,5):
  - states 1,2,3,5,6.
  - In I_EXEC: `alu_op`=000, `alu_src_b`=2.
  - In ALU_WB: `reg_write`=1, `wb_sel`=0, `pc_src`=0.
- Load (opcode 0000011, funct3 011):
  - states 1,2,3,7,8,9,10.
  - `mdr_load` only in 9; `reg_write` with `wb_sel`=1 only in 10.
- IR = 0x00000463 (beq x0,x0,+8):
  - with `zero`=1 in BRANCH: `pc_write`=1, `pc_src`=1.
  - Repeat with `zero`=0: `pc_src`=0.
  - bge (funct3 101) with `lt`=1: `pc_src`=0.
- IR = 0x010000EF (jal) → JAL: `wb_sel`=2, `pc_src`=1. IR = 0x123452B7 (lui) → LUI: `wb_sel`=3.
- IR = 0x00100073 (break), then R-type with funct7 0000001:
  - both enter HALT after DECODE or R_EXEC.
  - `halted`=1 with all write enables 0 for 10 or more cycles; reset recovers to state 0.
